// File: rtl/mips_trace_pkg.sv
// Shared types for the MIPS trace transmitter: snapshot layout, TX FSM states
// and the frame byte ordering.
package mips_trace_pkg;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] r1;
        logic [15:0] r2;
        logic [15:0] r3;
    } snapshot_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int FRAME_BYTES = 9;

    // Byte idx of a frame: sync first, then each register high byte before low byte.
    function automatic logic [7:0] frame_byte(input snapshot_t s, input logic [3:0] idx,
                                              input logic [7:0] sync);
        logic [7:0] b;
        case (idx)
            4'd0:    b = sync;
            4'd1:    b = s.pc[15:8];
            4'd2:    b = s.pc[7:0];
            4'd3:    b = s.r1[15:8];
            4'd4:    b = s.r1[7:0];
            4'd5:    b = s.r2[15:8];
            4'd6:    b = s.r2[7:0];
            4'd7:    b = s.r3[15:8];
            4'd8:    b = s.r3[7:0];
            default: b = sync;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mips_trace_tx_if.sv
// Core-side observation bus of the trace transmitter: sampled core state in,
// UART line and status out.
interface mips_trace_tx_if;
    logic        en;
    logic [15:0] pc;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [15:0] r3;
    logic        tx;
    logic        busy;
    logic [7:0]  drop_cnt;

    modport master (output en, pc, r1, r2, r3, input tx, busy, drop_cnt);
    modport slave  (input en, pc, r1, r2, r3, output tx, busy, drop_cnt);
endinterface

// File: rtl/trace_fifo.sv
// Synchronous snapshot FIFO; a push into a full FIFO is accepted only when a pop
// frees a slot on the same edge. DEPTH must be a power of 2.
module trace_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop_ok)  rptr <= rptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mips_trace_tx.sv
// Trace transmitter: captures {pc,r1,r2,r3} on every PC change and streams each
// snapshot as a 9-byte 8N1 UART frame.
//
// state | meaning
// IDLE  | line high; pops the next snapshot when the FIFO is non-empty
// START | start bit (tx=0) of byte byte_idx
// DATA  | data bit bit_idx of byte byte_idx, LSB first
// STOP  | stop bit (tx=1); then next byte or back to IDLE
module mips_trace_tx
    import mips_trace_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 16,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input logic           clk,
    input logic           rst_n,
    mips_trace_tx_if.slave bus
);
    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam int            FCW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_t      state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [2:0]     bit_idx, bit_nxt, bit_inc;
    logic [3:0]     byte_idx, byte_nxt;
    snapshot_t      frame, frame_nxt, snap, fifo_dout;
    logic           tx_q, tx_nxt, busy_q, busy_nxt;
    logic [7:0]     drop_cnt_q, cur_byte;
    logic [15:0]    pc_prev;
    logic           pc_prev_vld;
    logic           capture, drop, push, pop, wrap;
    logic           fifo_full, fifo_empty;
    logic [FCW-1:0] fifo_count, count_nxt;

    assign snap    = {bus.pc, bus.r1, bus.r2, bus.r3};
    assign capture = bus.en && (!pc_prev_vld || (bus.pc != pc_prev));
    assign drop    = capture && fifo_full && !pop;
    assign push    = capture && !drop;
    assign count_nxt = fifo_count + FCW'(push) - FCW'(pop);

    trace_fifo #(.WIDTH($bits(snapshot_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (snap),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign cur_byte = frame_byte(frame, byte_idx, SYNC_BYTE);
    assign wrap     = (cnt == CNT_LAST);
    assign bit_inc  = bit_idx + 3'd1;

    // tx_nxt is the line level for the cycle after this edge, so tx stays registered.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_idx;
        byte_nxt  = byte_idx;
        frame_nxt = frame;
        tx_nxt    = tx_q;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    frame_nxt = fifo_dout;
                    byte_nxt  = '0;
                    cnt_nxt   = '0;
                    state_nxt = START;
                    tx_nxt    = 1'b0;
                end
            end
            START: begin
                cnt_nxt = cnt + CW'(1);
                if (wrap) begin
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                    state_nxt = DATA;
                    tx_nxt    = cur_byte[0];
                end
            end
            DATA: begin
                cnt_nxt = cnt + CW'(1);
                if (wrap) begin
                    cnt_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_nxt = bit_inc;
                        tx_nxt  = cur_byte[bit_inc];
                    end
                end
            end
            STOP: begin
                cnt_nxt = cnt + CW'(1);
                if (wrap) begin
                    cnt_nxt = '0;
                    if (byte_idx < 4'(FRAME_BYTES - 1)) begin
                        byte_nxt  = byte_idx + 4'd1;
                        state_nxt = START;
                        tx_nxt    = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                        tx_nxt    = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE) || (count_nxt != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            frame       <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            drop_cnt_q  <= '0;
            pc_prev     <= '0;
            pc_prev_vld <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            bit_idx     <= bit_nxt;
            byte_idx    <= byte_nxt;
            frame       <= frame_nxt;
            tx_q        <= tx_nxt;
            busy_q      <= busy_nxt;
            pc_prev     <= bus.pc;
            pc_prev_vld <= 1'b1;
            if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign bus.tx       = tx_q;
    assign bus.busy     = busy_q;
    assign bus.drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_mips_trace_tx.sv
// Scoreboarded bench for mips_trace_tx: stimulus queues expected UART bytes, a
// line monitor decodes tx and checks bytes plus inter-byte start spacing.
module tb_mips_trace_tx;
    localparam int CPB = 4;

    typedef struct {
        logic [7:0] data;
        int         gap;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    bit   sb_en = 1'b1;
    exp_t exp_q[$];

    mips_trace_tx_if bus();

    mips_trace_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .SYNC_BYTE(8'hA5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_frame(input logic [15:0] pcv, r1v, r2v, r3v, input int first_gap);
        logic [7:0] fb [9];
        fb[0] = 8'hA5;        fb[1] = pcv[15:8]; fb[2] = pcv[7:0];
        fb[3] = r1v[15:8];    fb[4] = r1v[7:0];  fb[5] = r2v[15:8];
        fb[6] = r2v[7:0];     fb[7] = r3v[15:8]; fb[8] = r3v[7:0];
        for (int i = 0; i < 9; i++)
            exp_q.push_back('{data: fb[i], gap: (i == 0) ? first_gap : 10 * CPB});
    endfunction

    task automatic set_core(input logic [15:0] pcv, r1v, r2v, r3v);
        bus.pc = pcv; bus.r1 = r1v; bus.r2 = r2v; bus.r3 = r3v;
    endtask

    task automatic wait_drain(input string name, input int max);
        int n = 0;
        while ((bus.busy || exp_q.size() != 0) && n < max) begin
            step(1);
            n++;
        end
        compared++;
        if (bus.busy || exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL %s: drain timeout busy=%0b pending=%0d", name, bus.busy, exp_q.size());
        end
    endtask

    task automatic wait_tx_low(input string name, input int max);
        int n = 0;
        while (bus.tx !== 1'b0 && n < max) begin
            step(1);
            n++;
        end
        check(name, bus.tx, 1'b0);
    endtask

    // UART line monitor; abandons a byte in progress on reset.
    int         mon_cnt = 0;
    int         mon_start = 0;
    int         last_start = 0;
    bit         mon_act = 1'b0;
    logic [7:0] mon_byte;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (bus.tx === 1'b0) begin
                mon_act   = 1'b1;
                mon_cnt   = 0;
                mon_start = cyc;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt >= CPB + 1 && mon_cnt <= 8 * CPB + 1 && (mon_cnt - 1) % CPB == 0) begin
                mon_byte[(mon_cnt - 1) / CPB - 1] = bus.tx;
            end else if (mon_cnt == 9 * CPB + 1) begin
                mon_act = 1'b0;
                if (sb_en) begin
                    exp_t e;
                    check("stop_bit", bus.tx, 1'b1);
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_byte: got %02h expected none", mon_byte);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_byte", mon_byte, e.data);
                        if (e.gap != 0) check("byte_spacing", mon_start - last_start, e.gap);
                    end
                end
                last_start = mon_start;
            end
        end
    end

    initial begin
        int n;
        bus.en = 1'b0;
        set_core(16'h0, 16'h0, 16'h0, 16'h0);

        // 1: reset and quiescent outputs with en low
        step(2);
        check("rst_tx", bus.tx, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_drop", bus.drop_cnt, 8'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step(1);
            check("idle_tx", bus.tx, 1'b1);
            check("idle_busy", bus.busy, 1'b0);
            check("idle_drop", bus.drop_cnt, 8'd0);
        end

        // 2: first-cycle pc=0 snapshot followed by pc=4 snapshot
        bus.en = 1'b1;
        rst_n  = 1'b0;
        step(2);
        rst_n = 1'b1;
        push_frame(16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);
        step(1);
        set_core(16'h0004, 16'h0001, 16'h0002, 16'h0003);
        push_frame(16'h0004, 16'h0001, 16'h0002, 16'h0003, 10 * CPB + 1);
        step(1);
        wait_drain("single_frame", 2000);
        check("single_drop", bus.drop_cnt, 8'd0);

        // 3: one frame, busy timing, then a long hold with no traffic
        set_core(16'h0010, 16'h1111, 16'h2222, 16'h3333);
        push_frame(16'h0010, 16'h1111, 16'h2222, 16'h3333, 0);
        step(1);
        wait_tx_low("frame_start", 10);
        n = 0;
        while (bus.busy && n < 1000) begin
            step(1);
            n++;
        end
        check("busy_len", n, 90 * CPB);
        for (int i = 0; i < 500; i++) begin
            step(1);
            check("hold_tx", bus.tx, 1'b1);
            check("hold_busy", bus.busy, 1'b0);
        end

        // 4: seven consecutive pc changes, two dropped
        for (int i = 1; i <= 7; i++) begin
            set_core(16'h0100 + 16'(i), 16'h1000 + 16'(i), 16'h2000 + 16'(3 * i), 16'hBEEF ^ 16'(i));
            if (i <= 5)
                push_frame(16'h0100 + 16'(i), 16'h1000 + 16'(i), 16'h2000 + 16'(3 * i),
                           16'hBEEF ^ 16'(i), (i == 1) ? 0 : 10 * CPB + 1);
            step(1);
        end
        wait_drain("overflow", 4000);
        check("overflow_drop", bus.drop_cnt, 8'd2);

        // 5: reset during byte 3 with two snapshots still queued
        set_core(16'h0A00, 16'h1A1A, 16'h2A2A, 16'h3A3A);
        push_frame(16'h0A00, 16'h1A1A, 16'h2A2A, 16'h3A3A, 0);
        step(1);
        set_core(16'h0B00, 16'h1B1B, 16'h2B2B, 16'h3B3B);
        step(1);
        set_core(16'h0C00, 16'h1C1C, 16'h2C2C, 16'h3C3C);
        step(1);
        wait_tx_low("mid_start", 10);
        step(3 * 10 * CPB + 5);
        check("mid_busy_pre", bus.busy, 1'b1);
        rst_n = 1'b0;
        exp_q.delete();
        step(1);
        check("mid_rst_tx", bus.tx, 1'b1);
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_drop", bus.drop_cnt, 8'd0);
        rst_n = 1'b1;
        push_frame(16'h0C00, 16'h1C1C, 16'h2C2C, 16'h3C3C, 0);
        wait_drain("post_reset", 2000);

        // 6: pc toggling every cycle saturates the drop counter
        sb_en = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            bus.pc = (i % 2 == 1) ? 16'hAAAA : 16'h5555;
            step(1);
            if (i == 400) check("sat_drop_mid", bus.drop_cnt, 8'd255);
        end
        check("sat_drop_end", bus.drop_cnt, 8'd255);
        bus.en = 1'b0;
        rst_n  = 1'b0;
        exp_q.delete();
        step(2);
        rst_n = 1'b1;
        sb_en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step(1);
            check("final_tx", bus.tx, 1'b1);
            check("final_busy", bus.busy, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
